// File: rtl/wfq_deq_ctrl.sv
// wfq_deq_ctrl: per-queue descriptor FIFOs feeding a WFQ scheduler, with a
// dequeue FSM that requests arbitration, consumes the winner and presents the
// winning head descriptor on a valid/ready output stream.
// Optional feature macro: WFQ_DEQ_PIPE_EN -- when defined, an accepted output
// chains straight into the next arbitration request, skipping IDLE.
//
// state | meaning
// IDLE  | nothing in flight; waiting for any queue to become non-empty
// WAIT  | arbitration requested; waiting for the scheduler's winner
// OUT   | head descriptor held on deq_*; waiting for deq_rdy
module wfq_deq_ctrl #(
  parameter int QUEUE_NUM_WIDTH = 2,
  parameter int DATA_WIDTH      = 16,
  parameter int FIFO_AW         = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq_vld,
  input  logic [QUEUE_NUM_WIDTH-1:0]   enq_qid,
  input  logic [DATA_WIDTH-1:0]        enq_data,
  output logic                         enq_rdy,
  output logic [2**QUEUE_NUM_WIDTH-1:0] wfq_rdy,
  output logic                         wfq_sch_en,
  input  logic                         wfq_winner_vld,
  input  logic [QUEUE_NUM_WIDTH-1:0]   wfq_winner,
  output logic                         deq_vld,
  output logic [QUEUE_NUM_WIDTH-1:0]   deq_qid,
  output logic [DATA_WIDTH-1:0]        deq_data,
  input  logic                         deq_rdy,
  output logic                         err
);

  localparam int QUEUE_NUM = 2**QUEUE_NUM_WIDTH;
  localparam int DEPTH     = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [QUEUE_NUM][DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr [QUEUE_NUM];
  logic [FIFO_AW-1:0]    rd_ptr [QUEUE_NUM];
  logic [FIFO_AW:0]      cnt    [QUEUE_NUM];

  logic                  enq_fire;
  logic                  pop;
  logic                  set_err;
  logic                  deq_clr;
  logic                  sch_start;
  logic [QUEUE_NUM-1:0]  enq_hot;
  logic [QUEUE_NUM-1:0]  pop_hot;

  // enq_rdy looks at the pre-pop count, so a full queue stays closed in its pop cycle
  assign enq_rdy  = (cnt[enq_qid] != CNT_FULL);
  assign enq_fire = enq_vld & enq_rdy;

  // Non-empty flags straight from the registered counts
  always_comb begin
    wfq_rdy = '0;
    for (int i = 0; i < QUEUE_NUM; i++) begin
      wfq_rdy[i] = (cnt[i] != '0);
    end
  end

  // One-hot per-queue enqueue/pop strobes for the pointer/count update
  always_comb begin
    enq_hot = '0;
    pop_hot = '0;
    if (enq_fire) enq_hot[enq_qid] = 1'b1;
    if (pop)      pop_hot[wfq_winner] = 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state, pop strobe and error detection
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    set_err   = 1'b0;
    deq_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|wfq_rdy) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (wfq_winner_vld) begin
          if (wfq_rdy[wfq_winner]) begin
            pop       = 1'b1;
            state_nxt = ST_OUT;
          end else begin
            set_err   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_OUT: begin
        if (deq_rdy) begin
          deq_clr = 1'b1;
`ifdef WFQ_DEQ_PIPE_EN
          // counts already reflect this output's pop, so wfq_rdy is post-pop here
          state_nxt = (|wfq_rdy) ? ST_WAIT : ST_IDLE;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (wfq_winner_vld && (state != ST_WAIT)) set_err = 1'b1;
  end

  // Arbitration request fires on entry to WAIT only
  assign sch_start = (state_nxt == ST_WAIT) && (state != ST_WAIT);

  // Registered request pulse, output descriptor and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      wfq_sch_en <= 1'b0;
      deq_vld    <= 1'b0;
      deq_qid    <= '0;
      deq_data   <= '0;
      err        <= 1'b0;
    end else begin
      wfq_sch_en <= sch_start;
      if (pop) begin
        deq_vld  <= 1'b1;
        deq_qid  <= wfq_winner;
        deq_data <= mem[wfq_winner][rd_ptr[wfq_winner]];
      end else if (deq_clr) begin
        deq_vld  <= 1'b0;
      end
      if (set_err) err <= 1'b1;
    end
  end

  // Per-queue pointers and counts; simultaneous enqueue and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_NUM; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < QUEUE_NUM; i++) begin
        if (enq_hot[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop_hot[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({enq_hot[i], pop_hot[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Descriptor storage; contents are only visible through the counts, so no reset
  always_ff @(posedge clk) begin
    if (enq_fire) mem[enq_qid][wr_ptr[enq_qid]] <= enq_data;
  end

endmodule

// File: tb/tb_wfq_deq_ctrl.sv
// Bench for wfq_deq_ctrl: per-queue SV queues model the buffers, a scoreboard
// queue holds expected outputs, and a negedge monitor checks the output stream.
module tb_wfq_deq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_vld;
  logic [1:0]  enq_qid;
  logic [15:0] enq_data;
  logic        enq_rdy;
  logic [3:0]  wfq_rdy;
  logic        wfq_sch_en;
  logic        wfq_winner_vld;
  logic [1:0]  wfq_winner;
  logic        deq_vld;
  logic [1:0]  deq_qid;
  logic [15:0] deq_data;
  logic        deq_rdy;
  logic        err;

  wfq_deq_ctrl dut (
    .clk(clk), .rst(rst),
    .enq_vld(enq_vld), .enq_qid(enq_qid), .enq_data(enq_data), .enq_rdy(enq_rdy),
    .wfq_rdy(wfq_rdy), .wfq_sch_en(wfq_sch_en),
    .wfq_winner_vld(wfq_winner_vld), .wfq_winner(wfq_winner),
    .deq_vld(deq_vld), .deq_qid(deq_qid), .deq_data(deq_data), .deq_rdy(deq_rdy),
    .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [15:0] mq [4][$];
  logic [17:0] sb [$];
  int          xfer_t [$];
  bit          awaiting;
  bit          err_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] model_rdy();
    logic [3:0] r;
    for (int q = 0; q < 4; q++) r[q] = (mq[q].size() != 0);
    return r;
  endfunction

  // One clock of stimulus; the model advances by the same edge's rules
  task automatic step(input logic ev, input logic [1:0] eq, input logic [15:0] ed,
                      input logic wv, input logic [1:0] w, input logic dr);
    bit fire;
    enq_vld = ev; enq_qid = eq; enq_data = ed;
    wfq_winner_vld = wv; wfq_winner = w; deq_rdy = dr;
    #1;
    chk("enq_rdy", 32'(enq_rdy), 32'(mq[eq].size() < 8));
    fire = ev && (mq[eq].size() < 8);
    @(posedge clk);
    if (wv) begin
      if (!awaiting) err_exp = 1'b1;
      else begin
        awaiting = 1'b0;
        if (mq[w].size() == 0) err_exp = 1'b1;
        else sb.push_back({w, mq[w].pop_front()});
      end
    end
    if (fire) mq[eq].push_back(ed);
    #1;
    chk("wfq_rdy", 32'(wfq_rdy), 32'(model_rdy()));
    chk("err", 32'(err), 32'(err_exp));
    if (wfq_sch_en) begin
      chk("sch_en_while_waiting", 32'(awaiting), 32'(0));
      chk("sch_en_while_output_pending", 32'(sb.size()), 32'(0));
      awaiting = 1'b1;
    end
  endtask

  task automatic idle_step(input logic dr);
    step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, dr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enq_vld = 1'b0; enq_qid = 2'd0; enq_data = 16'h0;
    wfq_winner_vld = 1'b0; wfq_winner = 2'd0; deq_rdy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int q = 0; q < 4; q++) mq[q].delete();
    sb.delete();
    xfer_t.delete();
    awaiting = 1'b0;
    err_exp  = 1'b0;
    #1;
    chk("rst_deq_vld", 32'(deq_vld), 32'(0));
    chk("rst_deq_qid", 32'(deq_qid), 32'(0));
    chk("rst_deq_data", 32'(deq_data), 32'(0));
    chk("rst_wfq_rdy", 32'(wfq_rdy), 32'(0));
    chk("rst_sch_en", 32'(wfq_sch_en), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_enq_rdy", 32'(enq_rdy), 32'(1));
  endtask

  task automatic wait_sched();
    for (int i = 0; i < 20 && !awaiting; i++) idle_step(1'b0);
    chk("sched_timeout", 32'(awaiting), 32'(1));
  endtask

  task automatic serve(input logic [1:0] w);
    wait_sched();
    step(1'b0, 2'd0, 16'h0, 1'b1, w, 1'b0);
    idle_step(1'b1);
  endtask

  // Picks a winner among non-empty model queues; returns 0 in wv if none
  task automatic pick(output logic wv, output logic [1:0] w);
    int cand [$];
    wv = 1'b0; w = 2'd0;
    for (int q = 0; q < 4; q++) if (mq[q].size() != 0) cand.push_back(q);
    if (cand.size() != 0) begin
      wv = 1'b1;
      w  = 2'(cand[$urandom_range(cand.size() - 1)]);
    end
  endtask

  // Output monitor: every held cycle must match the scoreboard head
  always @(negedge clk) begin
    if (!rst && deq_vld) begin
      if (sb.size() == 0) begin
        chk("deq_unexpected", 32'(deq_vld), 32'(0));
      end else begin
        chk("deq_out", 32'({deq_qid, deq_data}), 32'(sb[0]));
        if (deq_rdy) begin
          void'(sb.pop_front());
          xfer_t.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       wv;
    logic [1:0] w;
    int         left;

    do_reset();

    // Single descriptor through q2
    step(1'b1, 2'd2, 16'h0011, 1'b0, 2'd0, 1'b0);
    serve(2'd2);

    // Fill q1, overflow attempt, drain in order
    for (int i = 0; i < 8; i++) step(1'b1, 2'd1, 16'(16'h0100 + i), 1'b0, 2'd0, 1'b0);
    step(1'b1, 2'd1, 16'hDEAD, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++) serve(2'd1);

    // Backpressure for 5 cycles in OUT
    step(1'b1, 2'd0, 16'h0BB0, 1'b0, 2'd0, 1'b0);
    wait_sched();
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) idle_step(1'b0);
    idle_step(1'b1);

    // Same-cycle enqueue and pop on q0 holding one descriptor
    step(1'b1, 2'd0, 16'h00A0, 1'b0, 2'd0, 1'b0);
    wait_sched();
    step(1'b1, 2'd0, 16'h00A1, 1'b1, 2'd0, 1'b0);
    idle_step(1'b1);
    serve(2'd0);

    // Winner names an empty queue
    step(1'b1, 2'd0, 16'h0C0C, 1'b0, 2'd0, 1'b0);
    wait_sched();
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'd3, 1'b0);
    serve(2'd0);

    // Winner pulse while idle
    do_reset();
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 1'b0);
    idle_step(1'b0);

    // Reset while an output is held
    step(1'b1, 2'd2, 16'h0222, 1'b0, 2'd0, 1'b0);
    step(1'b1, 2'd3, 16'h0333, 1'b0, 2'd0, 1'b0);
    wait_sched();
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 1'b0);
    idle_step(1'b0);
    do_reset();

    // Back-to-back output spacing with an immediate scheduler
    step(1'b1, 2'd0, 16'h0E01, 1'b0, 2'd0, 1'b1);
    step(1'b1, 2'd0, 16'h0E02, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 30 && xfer_t.size() < 2; i++) begin
      wv = 1'b0; w = 2'd0;
      if (awaiting) pick(wv, w);
      step(1'b0, 2'd0, 16'h0, wv, w, 1'b1);
    end
    if (xfer_t.size() >= 2) begin
`ifdef WFQ_DEQ_PIPE_EN
      chk("out_spacing", 32'(xfer_t[1] - xfer_t[0]), 32'(2));
`else
      chk("out_spacing", 32'(xfer_t[1] - xfer_t[0]), 32'(3));
`endif
    end else begin
      chk("spacing_timeout", 32'(xfer_t.size()), 32'(2));
    end

    // Random traffic with random scheduler latency and backpressure
    do_reset();
    for (int i = 0; i < 800; i++) begin
      wv = 1'b0; w = 2'd0;
      if (awaiting && ($urandom_range(1) == 1)) pick(wv, w);
      step(1'($urandom_range(1)), 2'($urandom_range(3)), 16'($urandom),
           wv, w, 1'($urandom_range(3) != 0));
    end
    for (int i = 0; i < 400; i++) begin
      left = sb.size();
      for (int q = 0; q < 4; q++) left += mq[q].size();
      if (left == 0 && !awaiting) break;
      wv = 1'b0; w = 2'd0;
      if (awaiting) pick(wv, w);
      step(1'b0, 2'd0, 16'h0, wv, w, 1'b1);
    end
    left = sb.size();
    for (int q = 0; q < 4; q++) left += mq[q].size();
    chk("drain_remaining", 32'(left), 32'(0));
    chk("drain_wfq_rdy", 32'(wfq_rdy), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
